// File: rtl/remote_comm.sv
// remote_comm: host side of the two-byte UART command link.
// Sends a 16-bit command as two back-to-back 8N1 frames, high byte first,
// and receives 8-bit responses on RX. The baud timing, TX serializer and
// RX deserializer are all built in here.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  // Last count of a full bit period, and of the half period up to the
  // middle of the start bit.
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Transmit side
  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  hold_lo_q, hold_lo_d;    // low byte, still needed once the high byte is in the shifter
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_bit_q, tx_bit_d;      // 0 = start, 1..8 = data, 9 = stop
  logic [15:0] tx_baud_q, tx_baud_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        cmd_snt_q, cmd_snt_d;
  logic        cmd_accept;

  // Receive side
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_baud_q, rx_baud_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  resp_q, resp_d;
  logic        resp_rdy_q, resp_rdy_d;
  logic        resp_set;

  // TX sequencing: start a command from IDLE, step bits every BAUD_DIV cycles,
  // chain the low frame straight after the high frame's stop bit.
  always_comb begin
    tx_state_d = tx_state_q;
    hold_lo_d  = hold_lo_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_baud_d  = tx_baud_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    cmd_snt_d  = cmd_snt_q;
    cmd_accept = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (snd_cmd) begin
          cmd_accept = 1'b1;
          tx_state_d = TX_HIGH;
          hold_lo_d  = cmd[7:0];
          tx_shift_d = cmd[15:8];
          tx_bit_d   = 4'd0;
          tx_baud_d  = 16'd0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          cmd_snt_d  = 1'b0;
        end
      end
      TX_HIGH, TX_LOW: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = 16'd0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = 4'd0;
            if (tx_state_q == TX_HIGH) begin
              tx_state_d = TX_LOW;
              tx_shift_d = hold_lo_q;
              tx_d       = 1'b0;
            end else begin
              tx_state_d = TX_IDLE;
              tx_d       = 1'b1;
              busy_d     = 1'b0;
              cmd_snt_d  = 1'b1;
            end
          end else begin
            // The shifter fills with ones, so after eight data bits the
            // ninth shift-out is the stop bit.
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[7:1]};
          end
        end else begin
          tx_baud_d = tx_baud_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX framing: detect the start edge, confirm the start bit mid-bit, then
  // sample eight data bits and the stop bit one bit period apart.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    resp_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_baud_d  = 16'd0;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;  // high here means it was a glitch
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = 16'd0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = 16'd0;
          rx_state_d = RX_IDLE;
          resp_set   = rx_sync_q;  // a low stop bit drops the byte silently
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Response flag: a fresh byte beats a clear in the same cycle.
  always_comb begin
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q;
    if (resp_set) begin
      resp_d     = rx_shift_q;
      resp_rdy_d = 1'b1;
    end else if (clr_resp_rdy || cmd_accept) begin
      resp_rdy_d = 1'b0;
    end
  end

  // Two-flop synchronizer for RX plus the previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // TX state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      hold_lo_q  <= 8'd0;
      tx_shift_q <= 8'd0;
      tx_bit_q   <= 4'd0;
      tx_baud_q  <= 16'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cmd_snt_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      hold_lo_q  <= hold_lo_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_baud_q  <= tx_baud_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      cmd_snt_q  <= cmd_snt_d;
    end
  end

  // RX state registers and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      resp_q     <= 8'd0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign cmd_snt  = cmd_snt_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: directed stimulus, a frame-level model of the
// expected outputs checked after every clock edge, plus literal spot checks.
module tb_remote_comm;

  localparam int BD     = 16;
  localparam int FRAME  = 10 * BD;
  // Edges from the edge before RX drops until the response is visible:
  // 2 synchronizer cycles, 1 edge-detect cycle, half a bit, nine bits.
  localparam int RX_LAT = 3 + BD / 2 + 9 * BD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        clr_resp_rdy = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;
  logic        tx, busy, cmd_snt, resp_rdy;
  logic [7:0]  resp;

  assign rx_line = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk          (clk),
    .rst          (rst),
    .snd_cmd      (snd_cmd),
    .cmd          (cmd),
    .clr_resp_rdy (clr_resp_rdy),
    .RX           (rx_line),
    .TX           (tx),
    .busy         (busy),
    .cmd_snt      (cmd_snt),
    .resp         (resp),
    .resp_rdy     (resp_rdy)
  );

  int checks   = 0;
  int failures = 0;
  int ecount   = 0;   // number of rising edges so far

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int         due;
    logic [7:0] b;
    logic       ok;
  } rx_ev_t;

  rx_ev_t      rxq[$];
  logic        m_busy = 1'b0;
  logic        m_snt  = 1'b0;
  logic        m_rdy  = 1'b0;
  logic [7:0]  m_resp = 8'h00;
  logic [15:0] m_cmd  = 16'h0000;
  int          m_acc  = 0;

  function automatic rx_ev_t mk_ev(input int due, input logic [7:0] b, input logic ok);
    rx_ev_t e;
    e.due = due;
    e.b   = b;
    e.ok  = ok;
    return e;
  endfunction

  // Line level t cycles into a two-frame command transfer.
  function automatic logic frame_bit(input logic [15:0] c, input int t);
    int         bitn, b;
    logic [7:0] by;
    bitn = t / BD;
    by   = (bitn < 10) ? c[15:8] : c[7:0];
    b    = bitn % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b - 1];
  endfunction

  // Advance the model on each edge and compare every output just after it.
  initial begin : compare
    logic        s, c, r, set_now, acc;
    logic [15:0] cm;
    rx_ev_t      ev;
    forever begin
      @(posedge clk);
      ecount++;
      s  = snd_cmd;
      c  = clr_resp_rdy;
      r  = rst;
      cm = cmd;
      #1;
      if (r) begin
        m_busy = 1'b0;
        m_snt  = 1'b0;
        m_rdy  = 1'b0;
        m_resp = 8'h00;
        rxq.delete();
      end else begin
        set_now = 1'b0;
        acc     = 1'b0;
        if (rxq.size() > 0 && rxq[0].due == ecount) begin
          ev = rxq.pop_front();
          if (ev.ok) begin
            m_resp  = ev.b;
            set_now = 1'b1;
          end
        end
        if (m_busy && (ecount - m_acc) == 2 * FRAME) begin
          m_busy = 1'b0;
          m_snt  = 1'b1;
        end else if (s && !m_busy) begin
          acc    = 1'b1;
          m_busy = 1'b1;
          m_snt  = 1'b0;
          m_cmd  = cm;
          m_acc  = ecount;
          if (loop_en) begin
            rxq.push_back(mk_ev(ecount + RX_LAT, cm[15:8], 1'b1));
            rxq.push_back(mk_ev(ecount + FRAME + RX_LAT, cm[7:0], 1'b1));
          end
        end
        if (set_now) m_rdy = 1'b1;
        else if (c || acc) m_rdy = 1'b0;
      end
      chk("model_tx", tx, m_busy ? frame_bit(m_cmd, ecount - m_acc) : 1'b1);
      chk("model_busy", busy, m_busy);
      chk("model_cmd_snt", cmd_snt, m_snt);
      chk("model_resp", resp, m_resp);
      chk("model_resp_rdy", resp_rdy, m_rdy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_edge(input int e);
    while (ecount < e) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] v, output int a);
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready", busy, 1'b0);
    snd_cmd = 1'b1;
    cmd     = v;
    a       = ecount + 1;
    @(negedge clk);
    snd_cmd = 1'b0;
    $display("send cmd=%h accepted at edge %0d", v, a);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    rxq.push_back(mk_ev(ecount + RX_LAT, b, stop));
    rx_drv = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BD) @(negedge clk);
    end
    rx_drv = stop;
    repeat (BD) @(negedge clk);
    rx_drv = 1'b1;
    $display("rx frame byte=%h stop=%0b driven, resp=%h resp_rdy=%0b", b, stop, resp, resp_rdy);
  endtask

  // Hand-derived frames for 16'hA5C3, indexed by bit slot 0..19.
  logic [19:0] pat_a5c3 = {10'b1110000110, 10'b1101001010};

  initial begin : stim
    int a;
    int due;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_snt", cmd_snt, 1'b0);
    chk("rst_resp", resp, 8'h00);
    chk("rst_resp_rdy", resp_rdy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Command A5C3, with an ignored FFFF request mid-transfer.
    send(16'hA5C3, a);
    chk("busy_first", busy, 1'b1);
    chk("start_bit", tx, 1'b0);
    for (int t = 0; t < 2 * FRAME; t++) begin
      wait_edge(a + t);
      if (t == 49) begin
        snd_cmd = 1'b1;
        cmd     = 16'hFFFF;
      end else if (t == 50) begin
        snd_cmd = 1'b0;
      end
      if (t % BD == BD / 2) chk("a5c3_bit", tx, pat_a5c3[t / BD]);
    end
    chk("busy_last", busy, 1'b1);
    wait_edge(a + 2 * FRAME);
    chk("a5c3_busy_done", busy, 1'b0);
    chk("a5c3_cmd_snt", cmd_snt, 1'b1);
    chk("a5c3_idle_tx", tx, 1'b1);
    $display("cmd a5c3 complete at edge %0d", ecount);

    // Good RX frame, then clear.
    repeat (5) @(negedge clk);
    drive_rx(8'h3C, 1'b1);
    chk("rx3c_resp", resp, 8'h3C);
    chk("rx3c_rdy", resp_rdy, 1'b1);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    chk("clr_rdy", resp_rdy, 1'b0);
    chk("clr_resp_held", resp, 8'h3C);

    // Framing error, then a one-cycle glitch.
    drive_rx(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    chk("ferr_resp", resp, 8'h3C);
    chk("ferr_rdy", resp_rdy, 1'b0);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * BD) @(negedge clk);
    chk("glitch_resp", resp, 8'h3C);
    chk("glitch_rdy", resp_rdy, 1'b0);
    chk("cmd_snt_level", cmd_snt, 1'b1);
    $display("glitch on RX ignored");

    // Reset during a send, then a clean command.
    send(16'hBEEF, a);
    wait_edge(a + 99);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cmd_snt", cmd_snt, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    send(16'h1234, a);
    wait_edge(a + BD + BD / 2);
    chk("c1234_d0", tx, 1'b0);
    wait_edge(a + 2 * BD + BD / 2);
    chk("c1234_d1", tx, 1'b1);
    wait_edge(a + 2 * FRAME);
    chk("c1234_cmd_snt", cmd_snt, 1'b1);
    chk("c1234_busy", busy, 1'b0);
    $display("cmd 1234 complete at edge %0d", ecount);

    // Loopback: high byte lands while a clear is asserted on the same edge.
    @(negedge clk);
    loop_en = 1'b1;
    send(16'h7E81, a);
    due = a + RX_LAT;
    wait_edge(due - 1);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    chk("loop_hi_rdy", resp_rdy, 1'b1);
    chk("loop_hi_resp", resp, 8'h7E);
    wait_edge(a + FRAME + RX_LAT);
    chk("loop_lo_resp", resp, 8'h81);
    chk("loop_lo_rdy", resp_rdy, 1'b1);
    wait_edge(a + 2 * FRAME + 2);
    chk("loop_cmd_snt", cmd_snt, 1'b1);
    loop_en = 1'b0;
    $display("loopback 7e81 received resp=%h", resp);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", ecount);
    $fatal(1, "timeout");
  end

endmodule
